// File: rtl/bcd2fx_pkg.sv
// rtl/bcd2fx_pkg.sv - shared types and constants for the BCD to fixed-point converter
// Purpose: FSM state enum, BCD digit type and the pow10 constant function.
// Ports: none (package).
package bcd2fx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INT,
      S_FACC,
      S_DIV,
      S_RND,
      S_DONE
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   // Elaboration-time 10^n; used to size accumulators and the divisor.
   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bcd2fx_frac_div.sv
// rtl/bcd2fx_frac_div.sv - one restoring-division step by 10^FRAC_DIGITS
// Purpose: rem_next/q for rem*2 compared against DEN = 10^FRAC_DIGITS.
// Ports: rem (current remainder, < DEN), rem_next (updated remainder), q (quotient bit).
module bcd2fx_frac_div
   import bcd2fx_pkg::*;
#(
   parameter int FRAC_DIGITS = 2,
   localparam int REM_W = $clog2(2 * pow10(FRAC_DIGITS) + 1)
) (
   input  logic [REM_W-1:0] rem,
   output logic [REM_W-1:0] rem_next,
   output logic             q
);

   localparam logic [REM_W-1:0] DEN = REM_W'(pow10(FRAC_DIGITS));

   logic [REM_W-1:0] dbl;

   // rem < DEN, so the doubled value always fits REM_W (sized for 2*DEN).
   assign dbl      = rem << 1;
   assign q        = (dbl >= DEN);
   assign rem_next = q ? (dbl - DEN) : dbl;

endmodule

// File: rtl/bcd_to_fixed_seq.sv
// rtl/bcd_to_fixed_seq.sv - sequential packed-BCD to unsigned fixed-point converter
// Purpose: accepts INT_DIGITS.FRAC_DIGITS BCD, produces {integer, fraction} with
//   INT_BITS.FRAC_BITS bits; integer overflow saturates to all ones with out_err.
// Macro: BCD2FX_ROUND_EN enables round-half-up of the fraction (default truncates).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_digits input handshake;
//   out_valid/out_ready/out_data/out_err result handshake; busy = not idle.
module bcd_to_fixed_seq
   import bcd2fx_pkg::*;
#(
   parameter int INT_DIGITS  = 2,
   parameter int FRAC_DIGITS = 2,
   parameter int INT_BITS    = 7,
   parameter int FRAC_BITS   = 6
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0]   in_digits,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [INT_BITS+FRAC_BITS-1:0]           out_data,
   output logic                                    out_err,
   output logic                                    busy
);

   localparam int ND    = INT_DIGITS + FRAC_DIGITS;
   localparam int INT_W = $clog2(pow10(INT_DIGITS));
   localparam int REM_W = $clog2(2 * pow10(FRAC_DIGITS) + 1);
   localparam int SUM_W = ((INT_W > INT_BITS) ? INT_W : INT_BITS) + 1;
   localparam int OUT_W = INT_BITS + FRAC_BITS;
   localparam int RES_W = SUM_W + FRAC_BITS;

   state_t               state;
   logic [7:0]           cnt;
   logic [4*ND-1:0]      dig_sh;
   logic [INT_W-1:0]     int_acc;
   logic [REM_W-1:0]     rem;
   logic [REM_W-1:0]     rem_next;
   logic                 q_bit;
   logic [FRAC_BITS-1:0] frac;
   bcd_digit_t           cur_digit;
   logic                 bad_nibble;
   logic [SUM_W-1:0]     int_ext;
   logic [RES_W-1:0]     res_full;
   logic                 ovf;
   logic [OUT_W-1:0]     res_data;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign cur_digit = dig_sh[4*ND-1 -: 4];

   always_comb begin
      bad_nibble = 1'b0;
      for (int i = 0; i < ND; i++) begin
         if (in_digits[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
      end
   end

   // FACC leaves the numerator in rem, so the divider starts from it directly.
   bcd2fx_frac_div #(.FRAC_DIGITS(FRAC_DIGITS)) u_div (
      .rem      (rem),
      .rem_next (rem_next),
      .q        (q_bit)
   );

   // One extra integer bit catches both a too-large integer and a rounding carry.
   assign int_ext = SUM_W'(int_acc);
`ifdef BCD2FX_ROUND_EN
   // After the last DIV step, q_bit on the final remainder is exactly 2*rem >= DEN.
   assign res_full = {int_ext, frac} + RES_W'(q_bit);
`else
   assign res_full = {int_ext, frac};
`endif
   assign ovf      = |res_full[RES_W-1:OUT_W];
   assign res_data = ovf ? '1 : res_full[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         dig_sh    <= '0;
         int_acc   <= '0;
         rem       <= '0;
         frac      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  dig_sh  <= in_digits;
                  int_acc <= '0;
                  rem     <= '0;
                  frac    <= '0;
                  cnt     <= '0;
                  if (bad_nibble) begin
                     out_data  <= '0;
                     out_err   <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     state <= S_INT;
                  end
               end
            end
            S_INT: begin
               int_acc <= int_acc * INT_W'(10) + INT_W'(cur_digit);
               dig_sh  <= dig_sh << 4;
               if (cnt == 8'(INT_DIGITS - 1)) begin
                  cnt   <= '0;
                  state <= S_FACC;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_FACC: begin
               rem    <= rem * REM_W'(10) + REM_W'(cur_digit);
               dig_sh <= dig_sh << 4;
               if (cnt == 8'(FRAC_DIGITS - 1)) begin
                  cnt   <= '0;
                  state <= S_DIV;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DIV: begin
               rem  <= rem_next;
               frac <= {frac[FRAC_BITS-2:0], q_bit};
               if (cnt == 8'(FRAC_BITS - 1)) begin
                  cnt   <= '0;
                  state <= S_RND;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_RND: begin
               out_data  <= res_data;
               out_err   <= ovf;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_fixed_seq.sv
// tb/tb_bcd_to_fixed_seq.sv - directed self-checking bench for bcd_to_fixed_seq
// Purpose: instance a = default parameters; instance b = FRAC_DIGITS 3, INT_BITS 6.
// Ports: none (top-level bench).
module tb_bcd_to_fixed_seq;

`ifdef BCD2FX_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        out_ready = 1'b0;

   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [15:0] a_in_digits = '0;
   logic        a_out_valid;
   logic [12:0] a_out_data;
   logic        a_out_err;
   logic        a_busy;

   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [19:0] b_in_digits = '0;
   logic        b_out_valid;
   logic [11:0] b_out_data;
   logic        b_out_err;
   logic        b_busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        sel = 1'b0;

   logic        m_valid, m_ready, m_err, m_busy;
   logic [31:0] m_data;

   assign m_valid = sel ? b_out_valid : a_out_valid;
   assign m_ready = sel ? b_in_ready  : a_in_ready;
   assign m_err   = sel ? b_out_err   : a_out_err;
   assign m_busy  = sel ? b_busy      : a_busy;
   assign m_data  = sel ? 32'(b_out_data) : 32'(a_out_data);

   always #5 clk = ~clk;

   bcd_to_fixed_seq u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_digits (a_in_digits),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_data  (a_out_data),
      .out_err   (a_out_err),
      .busy      (a_busy)
   );

   bcd_to_fixed_seq #(.FRAC_DIGITS(3), .INT_BITS(6)) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_digits (b_in_digits),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_data  (b_out_data),
      .out_err   (b_out_err),
      .busy      (b_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Accept one input, measure edges to out_valid, hold out_ready low for
   // `hold` cycles, then complete the handshake.
   task automatic run(input string tag, input bit s, input logic [19:0] d,
                      input int exp_data, input bit exp_err, input int exp_lat,
                      input int hold);
      int lat;
      sel = s;
      #1;
      check({tag, "_in_ready"}, 32'(m_ready), 32'd1);
      if (s) begin
         b_in_digits = d;
         b_in_valid  = 1'b1;
      end else begin
         a_in_digits = d[15:0];
         a_in_valid  = 1'b1;
      end
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      check({tag, "_busy"}, 32'(m_busy), 32'd1);
      lat = 0;
      while (!m_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_data"}, m_data, 32'(exp_data));
      check({tag, "_err"}, 32'(m_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
         check({tag, "_hold_data"}, m_data, 32'(exp_data));
         check({tag, "_hold_in_ready"}, 32'(m_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_release_in_ready"}, 32'(m_ready), 32'd1);
      check({tag, "_release_valid"}, 32'(m_valid), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(a_out_valid), 32'd0);
      check("rst_data", 32'(a_out_data), 32'd0);
      check("rst_err", 32'(a_out_err), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(a_in_ready), 32'd1);

      run("a_03_75", 1'b0, 20'h00375, 240, 1'b0, 11, 5);
      run("a_12_03", 1'b0, 20'h01203, RND ? 770 : 769, 1'b0, 11, 0);
      run("a_bad_int", 1'b0, 20'h01A00, 0, 1'b1, 0, 0);
      run("a_bad_frac", 1'b0, 20'h0000F, 0, 1'b1, 0, 0);
      run("a_99_99", 1'b0, 20'h09999, 6399, 1'b0, 11, 0);
      run("a_00_00", 1'b0, 20'h00000, 0, 1'b0, 11, 0);
      run("a_00_50", 1'b0, 20'h00050, 32, 1'b0, 11, 0);

      run("b_09_999", 1'b1, 20'h09999, RND ? 640 : 639, 1'b0, 12, 0);
      run("b_00_008", 1'b1, 20'h00008, RND ? 1 : 0, 1'b0, 12, 0);
      run("b_63_999", 1'b1, 20'h63999, 4095, RND, 12, 0);
      run("b_64_000", 1'b1, 20'h64000, 4095, 1'b1, 12, 0);

      // Reset in the middle of DIV (edges 5..10 after accept).
      sel = 1'b0;
      a_in_digits = 16'h0375;
      a_in_valid  = 1'b1;
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(a_out_valid), 32'd0);
      check("mid_rst_data", 32'(a_out_data), 32'd0);
      check("mid_rst_err", 32'(a_out_err), 32'd0);
      check("mid_rst_busy", 32'(a_busy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("mid_rst_no_output", 32'(a_out_valid), 32'd0);
      run("a_after_rst", 1'b0, 20'h01203, RND ? 770 : 769, 1'b0, 11, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
